batch_dump_ctrl: RTL and testbench

BATCH_DUMP_CTRL -- requirements
Module: batch_dump_ctrl

---
 rtl/trng_ctrl_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/batch_dump_ctrl.sv | 177 +++++++++++++++++
 tb/tb_batch_dump_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_ctrl_pkg.sv
// Shared definitions for the TRNG batch dump controller: state encoding,
// default command bytes and a small command-match helper.
package trng_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        WAIT_DONE = 3'd2,
        READ      = 3'd3,
        LATCH     = 3'd4,
        SEND      = 3'd5,
        FINISH    = 3'd6
    } state_t;

    localparam logic [7:0] CMD_START_DEFAULT = 8'h53;  // 'S'
    localparam logic [7:0] CMD_ABORT_DEFAULT = 8'h41;  // 'A'

    // True when a strobed command byte matches the given code.
    function automatic logic is_cmd(input logic valid, input logic [7:0] data,
                                    input logic [7:0] code);
        return valid && (data == code);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow level signals crossing into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/batch_dump_ctrl.sv
// Batch dump controller: on a start command, raises coll_start, waits for the
// collector to finish, then streams BATCH_SIZE bytes from the collector memory
// to the UART transmitter, one byte per READ/LATCH/SEND round.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for CMD_START
// ARM       | one cycle, collector start raised, timeout counter cleared
// WAIT_DONE | waiting for synchronized done, bounded by TIMEOUT_CYCLES
// READ      | rd_en pulse with rd_addr = idx
// LATCH     | capture rd_data into tx_data, raise tx_valid
// SEND      | hold tx_valid/tx_data until tx_ready
// FINISH    | start held low for HOLD_CYCLES and until done drops
module batch_dump_ctrl
    import trng_ctrl_pkg::*;
#(
    parameter int unsigned BATCH_SIZE     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter logic [7:0]  CMD_START      = CMD_START_DEFAULT,
    parameter logic [7:0]  CMD_ABORT      = CMD_ABORT_DEFAULT,
    parameter int unsigned HOLD_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    output logic        coll_start,
    input  logic        coll_done,
    output logic        rd_en,
    output logic [31:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [31:0] IDX_LAST     = 32'(BATCH_SIZE - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);

    state_t      state;
    logic [31:0] idx;
    logic [31:0] cnt;    // timeout counter in WAIT_DONE, hold counter in FINISH
    logic        done_s;
    logic        start_cmd;
    logic        abort_cmd;

    sync_2ff #(.WIDTH(1)) u_done_sync (
        .clk (clk),
        .rst (rst),
        .d   (coll_done),
        .q   (done_s)
    );

    assign start_cmd = is_cmd(cmd_valid, cmd_data, CMD_START);
    assign abort_cmd = is_cmd(cmd_valid, cmd_data, CMD_ABORT);

    // Sequencer with all outputs registered; outputs change on state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            coll_start  <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        state       <= ARM;
                        idx         <= '0;
                        timeout_err <= 1'b0;
                        coll_start  <= 1'b1;
                        busy        <= 1'b1;
                    end
                end

                ARM: begin
                    cnt   <= '0;
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (abort_cmd) begin
                        state      <= FINISH;
                        cnt        <= '0;
                        coll_start <= 1'b0;
                    end else if (done_s) begin
                        state   <= READ;
                        rd_en   <= 1'b1;
                        rd_addr <= idx;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state       <= FINISH;
                        cnt         <= '0;
                        coll_start  <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                READ: begin
                    rd_en <= 1'b0;
                    if (abort_cmd) begin
                        state      <= FINISH;
                        cnt        <= '0;
                        coll_start <= 1'b0;
                    end else begin
                        state <= LATCH;
                    end
                end

                LATCH: begin
                    if (abort_cmd) begin
                        state      <= FINISH;
                        cnt        <= '0;
                        coll_start <= 1'b0;
                    end else begin
                        tx_data  <= rd_data;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                end

                SEND: begin
                    // An abort that lands on the handshake edge still lets
                    // that byte go out; only later bytes are dropped.
                    if (abort_cmd) begin
                        state      <= FINISH;
                        cnt        <= '0;
                        coll_start <= 1'b0;
                        tx_valid   <= 1'b0;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (idx == IDX_LAST) begin
                            state      <= FINISH;
                            cnt        <= '0;
                            coll_start <= 1'b0;
                        end else begin
                            idx     <= idx + 32'd1;
                            rd_addr <= idx + 32'd1;
                            rd_en   <= 1'b1;
                            state   <= READ;
                        end
                    end
                end

                FINISH: begin
                    // Collector must see start low long enough and drop done
                    // before the next batch may be armed.
                    if ((cnt >= HOLD_LAST) && !done_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt < HOLD_LAST) begin
                        cnt <= cnt + 32'd1;
                    end
                end

                default: begin
                    state      <= IDLE;
                    coll_start <= 1'b0;
                    rd_en      <= 1'b0;
                    tx_valid   <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_batch_dump_ctrl.sv
// Directed bench for batch_dump_ctrl with a small collector model and a
// negedge monitor that logs handshakes, reads and phase lengths.
module tb_batch_dump_ctrl;

    localparam int BS       = 4;
    localparam int TO       = 100;
    localparam int HOLD     = 16;
    localparam int DONE_DLY = 50;
    localparam logic [7:0] C_START = 8'h53;
    localparam logic [7:0] C_ABORT = 8'h41;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        coll_start;
    logic        coll_done;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [7:0]  rd_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        timeout_err;

    batch_dump_ctrl #(
        .BATCH_SIZE     (BS),
        .TIMEOUT_CYCLES (TO),
        .CMD_START      (C_START),
        .CMD_ABORT      (C_ABORT),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_data    (cmd_data),
        .coll_start  (coll_start),
        .coll_done   (coll_done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:3] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};

    // Collector model: done rises DONE_DLY cycles after start, drops with start.
    int   coll_cnt;
    logic done_en = 1'b1;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_cnt  <= 0;
            coll_done <= 1'b0;
            rd_data   <= 8'h00;
        end else begin
            if (rd_en) rd_data <= mem[rd_addr[1:0]];
            if (!coll_start) begin
                coll_cnt  <= 0;
                coll_done <= 1'b0;
            end else if (coll_cnt == DONE_DLY - 1) begin
                coll_done <= done_en;
            end else begin
                coll_cnt <= coll_cnt + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_got = 0, n_rd = 0, cs_cyc = 0, fin_cyc = 0, tv_cyc = 0;
    logic [7:0]  byte_log [0:63];
    int          hs_at    [0:63];
    logic [31:0] rd_log   [0:63];

    // Monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready && n_got < 64) begin
                byte_log[n_got] <= tx_data;
                hs_at[n_got]    <= cyc;
                n_got           <= n_got + 1;
            end
            if (rd_en && n_rd < 64) begin
                rd_log[n_rd] <= rd_addr;
                n_rd         <= n_rd + 1;
            end
            if (coll_start)          cs_cyc  <= cs_cyc + 1;
            if (busy && !coll_start) fin_cyc <= fin_cyc + 1;
            if (tx_valid)            tv_cyc  <= tv_cyc + 1;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; the command is sampled on the following edge.
    task automatic send_cmd(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk(tag, 32'(busy), 32'd0);
        step(2);
    endtask

    // Returns at posedge+1 with the DUT in LATCH for the given address.
    task automatic wait_rd(input string tag, input logic [31:0] addr);
        int   k = 0;
        logic seen = 1'b0;
        while (!seen && k < 1000) begin
            @(negedge clk);
            if (rd_en && rd_addr == addr) seen = 1'b1;
            k++;
        end
        chk(tag, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_bytes(input string tag, input int base, input int n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(byte_log[base + i]), 32'(mem[i]));
    endtask

    int b_got, b_rd, b_cs, b_fin, b_tv, held;

    initial begin
        rst = 1'b1;
        step(3);
        @(negedge clk);
        chk("rst_coll_start", 32'(coll_start), 32'd0);
        chk("rst_rd_en",      32'(rd_en),      32'd0);
        chk("rst_tx_valid",   32'(tx_valid),   32'd0);
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_timeout",    32'(timeout_err), 32'd0);
        chk("rst_rd_addr",    rd_addr,         32'd0);
        chk("rst_tx_data",    32'(tx_data),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);

        // Non-start command in IDLE is ignored.
        send_cmd(8'h58);
        step(2);
        chk("idle_ignore_busy", 32'(busy), 32'd0);

        // Plain batch, tx_ready high.
        b_got = n_got; b_rd = n_rd; b_cs = cs_cyc; b_fin = fin_cyc;
        send_cmd(C_START);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_coll_start", 32'(coll_start), 32'd1);
        wait_idle("t1_idle");
        chk("t1_count", 32'(n_got - b_got), 32'd4);
        check_bytes("t1", b_got, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_addr%0d", i), rd_log[b_rd + i], 32'(i));
        chk("t1_rd_count", 32'(n_rd - b_rd), 32'd4);
        chk("t1_start_cycles", 32'(cs_cyc - b_cs), 32'd65);
        chk("t1_finish_cycles", 32'(fin_cyc - b_fin), 32'd16);
        chk("t1_byte_period", 32'(hs_at[b_got + 1] - hs_at[b_got]), 32'd3);
        chk("t1_byte_period3", 32'(hs_at[b_got + 3] - hs_at[b_got + 2]), 32'd3);
        chk("t1_timeout_err", 32'(timeout_err), 32'd0);

        // Transmitter stalls on byte 1.
        b_got = n_got;
        send_cmd(C_START);
        wait_rd("t2_rd1", 32'd1);
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
        held = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_valid && tx_data == mem[1]) held++;
        end
        chk("t2_hold", 32'(held), 32'd10);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_idle("t2_idle");
        chk("t2_count", 32'(n_got - b_got), 32'd4);
        check_bytes("t2", b_got, 4);

        // Collector never finishes.
        done_en = 1'b0;
        b_got = n_got; b_cs = cs_cyc; b_fin = fin_cyc; b_tv = tv_cyc;
        send_cmd(C_START);
        wait_idle("t3_idle");
        chk("t3_start_cycles", 32'(cs_cyc - b_cs), 32'd101);
        chk("t3_finish_cycles", 32'(fin_cyc - b_fin), 32'd16);
        chk("t3_timeout_err", 32'(timeout_err), 32'd1);
        chk("t3_no_tx_valid", 32'(tv_cyc - b_tv), 32'd0);
        chk("t3_no_bytes", 32'(n_got - b_got), 32'd0);
        done_en = 1'b1;
        b_got = n_got;
        send_cmd(C_START);
        chk("t3_err_cleared", 32'(timeout_err), 32'd0);
        wait_idle("t3b_idle");
        chk("t3b_count", 32'(n_got - b_got), 32'd4);

        // Abort while byte 2 waits in SEND.
        b_got = n_got; b_rd = n_rd; b_fin = fin_cyc;
        send_cmd(C_START);
        wait_rd("t4_rd2", 32'd2);
        tx_ready = 1'b0;
        step(3);
        send_cmd(C_ABORT);
        chk("t4_abort_tx_valid", 32'(tx_valid), 32'd0);
        chk("t4_abort_coll_start", 32'(coll_start), 32'd0);
        chk("t4_abort_busy", 32'(busy), 32'd1);
        tx_ready = 1'b1;
        wait_idle("t4_idle");
        chk("t4_count", 32'(n_got - b_got), 32'd2);
        check_bytes("t4", b_got, 2);
        chk("t4_rd_count", 32'(n_rd - b_rd), 32'd3);
        chk("t4_finish_cycles", 32'(fin_cyc - b_fin), 32'd16);

        // Start commands while busy are ignored.
        b_got = n_got; b_rd = n_rd;
        send_cmd(C_START);
        step(10);
        send_cmd(C_START);
        wait_rd("t5_rd1", 32'd1);
        tx_ready = 1'b0;
        step(3);
        send_cmd(C_START);
        tx_ready = 1'b1;
        wait_idle("t5_idle");
        chk("t5_count", 32'(n_got - b_got), 32'd4);
        check_bytes("t5", b_got, 4);
        chk("t5_rd_count", 32'(n_rd - b_rd), 32'd4);

        // Reset pulse while in LATCH.
        b_got = n_got;
        send_cmd(C_START);
        wait_rd("t6_rd1", 32'd1);
        rst = 1'b1;
        #2;
        chk("t6_rst_coll_start", 32'(coll_start), 32'd0);
        chk("t6_rst_rd_en",      32'(rd_en),      32'd0);
        chk("t6_rst_tx_valid",   32'(tx_valid),   32'd0);
        chk("t6_rst_busy",       32'(busy),       32'd0);
        chk("t6_rst_rd_addr",    rd_addr,         32'd0);
        chk("t6_rst_tx_data",    32'(tx_data),    32'd0);
        step(3);
        chk("t6_rst_hold_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(5);
        chk("t6_post_busy", 32'(busy), 32'd0);
        chk("t6_post_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_partial_count", 32'(n_got - b_got), 32'd1);
        b_got = n_got; b_cs = cs_cyc;
        send_cmd(C_START);
        wait_idle("t6_idle");
        chk("t6_count", 32'(n_got - b_got), 32'd4);
        check_bytes("t6", b_got, 4);
        chk("t6_start_cycles", 32'(cs_cyc - b_cs), 32'd65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
